spram_gen: RTL



---
 rtl/spram_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spram_gen.sv
// spram_gen: parametrised single-port RAM with byte-lane write enables,
// selectable read latency (bypass or output register) and write-collision
// behaviour on dout (hold / write-through / read-before-write).
// Optional post-reset clear sequencer compiled in with SPRAM_GEN_CLEAR_EN;
// while it runs, busy=1 and user accesses are dropped.
//
// Handshake: there is no valid/ready pair. An access is taken on every
// rising edge where ce=1, busy=0 and reset=0. Read data follows a fixed
// latency (1 edge for READ_MODE 0, 2 edges with oce=1 for READ_MODE 1).
module spram_gen #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     ad,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  busy
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic              acc;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_cnt;

`ifdef SPRAM_GEN_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    state_t state;
    state_t state_nxt;

    // State register and clear address counter; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    // Next state: leave CLEAR once the last word is being written.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            CLEAR:   if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the sequencer owns the array for the whole CLEAR state.
    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR) && !reset;
    end
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_cnt = '0;
`endif

    assign acc      = ce && !busy && !reset;
    assign old_word = mem[ad];

    // Merged write word: new lanes where be=1, old lanes elsewhere.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) merged_word[8*i +: 8] = din[8*i +: 8];
        end
    end

    // Array write port: clear sweep has priority, then byte-lane user writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= CLR_VAL;
        end else if (acc && wre) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[ad][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Stage 1 read register, with the write-collision behaviour selected by WRITE_MODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= '0;
        end else if (acc) begin
            if (wre) begin
                if (WRITE_MODE == 1)      stage1 <= merged_word;
                else if (WRITE_MODE == 2) stage1 <= old_word;
            end else begin
                stage1 <= old_word;
            end
        end
    end

    // Output register: loads stage 1 whenever oce=1, independent of ce.
    always_ff @(posedge clk) begin
        if (reset) out_reg <= '0;
        else if (oce) out_reg <= stage1;
    end

    assign dout = (READ_MODE == 1) ? out_reg : stage1;

endmodule
